// File: rtl/mem_pkg.sv
// Shared types and sizes for the backend load path (request/response records, tag width).
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package mem_pkg;

  localparam int WORD_SIZE = 64;
  localparam int LQ_SIZE   = 16;
  localparam int TAG_W     = $clog2(LQ_SIZE);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] addr;
    tag_t                 tag;
  } mem_req_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] data;
    tag_t                 tag;
  } mem_resp_t;

  // Number of set bits in a tag bitmap; result is wide enough for all tags set.
  function automatic logic [TAG_W:0] count_tags(input logic [LQ_SIZE-1:0] bits);
    logic [TAG_W:0] n;
    n = '0;
    for (int i = 0; i < LQ_SIZE; i++) begin
      n = n + {{TAG_W{1'b0}}, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous FIFO with wrap-around pointers, occupancy count and a registered head entry.
// Latency: a push into an empty FIFO is visible at the head on the next cycle.
// Backpressure: pushes are ignored when full; clear empties it and overrides push/pop that cycle.
module mem_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             full
);

  // DEPTH must be at least 2 so the pointers have at least one bit.
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic [WIDTH-1:0] head_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign head_vld = (count_q != '0);
  assign full     = (count_q == FULL_CNT);
  assign head_dat = head_q;
  assign do_push  = push_vld && !full && !clear;
  assign do_pop   = pop && head_vld && !clear;

  // Storage array: written on push only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers, occupancy and the head copy that feeds the output port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + ONE_CNT;
        2'b01:   count_q <= count_q - ONE_CNT;
        default: ;
      endcase
      // Head only moves on pop or on a push into an empty FIFO, so it stays stable while stalled.
      if (do_pop) begin
        if (count_q > ONE_CNT) head_q <= mem[ptr_inc(rd_ptr)];
        else if (do_push)      head_q <= push_dat;
      end else if (do_push && !head_vld) begin
        head_q <= push_dat;
      end
    end
  end

endmodule

// File: rtl/mem_load_responder.sv
// Memory-side load endpoint: queues tagged loads, issues them to the data cache, returns tagged data.
// Latency: request -> dc_req_valid_out next cycle; cache response -> resp_valid_out next cycle.
// Backpressure: none toward the backend (drops flagged in err_out); cache port stalls on dc_req_ready_in.
module mem_load_responder
  import mem_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  input  logic                 flush_in,
  input  logic                 req_valid_in,
  input  logic [WORD_SIZE-1:0] req_addr_in,
  input  logic [TAG_W-1:0]     req_tag_in,
  output logic                 dc_req_valid_out,
  input  logic                 dc_req_ready_in,
  output logic [WORD_SIZE-1:0] dc_req_addr_out,
  output logic [TAG_W-1:0]     dc_req_id_out,
  input  logic                 dc_resp_valid_in,
  input  logic [WORD_SIZE-1:0] dc_resp_data_in,
  input  logic [TAG_W-1:0]     dc_resp_id_in,
  output logic                 resp_valid_out,
  output logic [WORD_SIZE-1:0] resp_data_out,
  output logic [TAG_W-1:0]     resp_tag_out,
  output logic [TAG_W:0]       outstanding_out,
  output logic                 idle_out,
  output logic [2:0]           err_out
);

  mem_req_t           push_req;
  mem_req_t           head_req;
  logic               fifo_vld;
  logic               fifo_full;
  logic               fifo_pop;
  logic               accept;

  // live: allocated and not squashed; issued: live tags already handed to the cache;
  // squashed: flushed tags whose cache response is still owed.
  logic [LQ_SIZE-1:0] live_q, live_d, live_free;
  logic [LQ_SIZE-1:0] squashed_q, squashed_d, sq_free;
  logic [LQ_SIZE-1:0] issued_q, issued_d, issued_now;
  logic [LQ_SIZE-1:0] resp_oh, pop_oh, req_oh;
  logic               spurious, dup_tag, overflow, deliver;
  logic [2:0]         err_q;
  mem_resp_t          resp_q;
  logic               resp_vld_q;

  assign push_req = '{addr: req_addr_in, tag: req_tag_in};
  assign fifo_pop = fifo_vld && dc_req_ready_in;

  mem_req_fifo #(
    .WIDTH ($bits(mem_req_t)),
    .DEPTH (LQ_SIZE)
  ) u_req_fifo (
    .clk      (clk_in),
    .rst_n    (rst_N_in),
    .clear    (flush_in),
    .push_vld (accept),
    .push_dat (push_req),
    .pop      (fifo_pop),
    .head_vld (fifo_vld),
    .head_dat (head_req),
    .full     (fifo_full)
  );

  // Tag bookkeeping: response frees first, then the new request allocates; flush squashes.
  always_comb begin
    resp_oh = '0;
    pop_oh  = '0;
    req_oh  = '0;
    if (dc_resp_valid_in) resp_oh[dc_resp_id_in] = 1'b1;
    if (fifo_pop)         pop_oh[head_req.tag]   = 1'b1;
    req_oh[req_tag_in] = 1'b1;

    spurious  = dc_resp_valid_in && !live_q[dc_resp_id_in] && !squashed_q[dc_resp_id_in];
    deliver   = dc_resp_valid_in && live_q[dc_resp_id_in] && !flush_in;
    live_free = live_q & ~resp_oh;
    sq_free   = squashed_q & ~resp_oh;

    dup_tag  = req_valid_in && !flush_in && (live_free[req_tag_in] || sq_free[req_tag_in]);
    overflow = req_valid_in && !flush_in && !dup_tag && fifo_full;
    accept   = req_valid_in && !flush_in && !dup_tag && !fifo_full;

    // A handshake completing this cycle counts as issued, so a flush now squashes it.
    issued_now = (issued_q | pop_oh) & ~resp_oh;

    if (flush_in) begin
      live_d     = '0;
      squashed_d = sq_free | (live_free & issued_now);
      issued_d   = '0;
    end else begin
      live_d     = live_free | (accept ? req_oh : '0);
      squashed_d = sq_free;
      issued_d   = issued_now;
    end
  end

  // Bitmaps and sticky error flags.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      live_q     <= '0;
      squashed_q <= '0;
      issued_q   <= '0;
      err_q      <= '0;
    end else begin
      live_q     <= live_d;
      squashed_q <= squashed_d;
      issued_q   <= issued_d;
      err_q      <= err_q | {spurious, dup_tag, overflow};
    end
  end

  // One-cycle response pulse toward the backend; payload only loads on a delivered response.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      resp_vld_q <= 1'b0;
      resp_q     <= '0;
    end else begin
      resp_vld_q <= deliver;
      if (deliver) resp_q <= '{data: dc_resp_data_in, tag: dc_resp_id_in};
    end
  end

  assign dc_req_valid_out = fifo_vld;
  assign dc_req_addr_out  = head_req.addr;
  assign dc_req_id_out    = head_req.tag;
  assign resp_valid_out   = resp_vld_q;
  assign resp_data_out    = resp_q.data;
  assign resp_tag_out     = resp_q.tag;
  assign outstanding_out  = count_tags(live_q);
  assign idle_out         = !fifo_vld && (live_q == '0) && (squashed_q == '0);
  assign err_out          = err_q;

endmodule

// File: tb/tb_mem_load_responder.sv
// Directed bench for mem_load_responder: single load, backpressure, out-of-order, flush, errors, reset.
// Inputs change on the falling edge; outputs are compared on the falling edge after the active edge.
// The cache ready input is driven per scenario.
module tb_mem_load_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [3:0]  req_tag;
  logic        dc_req_valid;
  logic        dc_req_ready;
  logic [63:0] dc_req_addr;
  logic [3:0]  dc_req_id;
  logic        dc_resp_valid;
  logic [63:0] dc_resp_data;
  logic [3:0]  dc_resp_id;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic [3:0]  resp_tag;
  logic [4:0]  outstanding;
  logic        idle;
  logic [2:0]  err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_load_responder dut (
    .clk_in           (clk),
    .rst_N_in         (rst_n),
    .flush_in         (flush),
    .req_valid_in     (req_valid),
    .req_addr_in      (req_addr),
    .req_tag_in       (req_tag),
    .dc_req_valid_out (dc_req_valid),
    .dc_req_ready_in  (dc_req_ready),
    .dc_req_addr_out  (dc_req_addr),
    .dc_req_id_out    (dc_req_id),
    .dc_resp_valid_in (dc_resp_valid),
    .dc_resp_data_in  (dc_resp_data),
    .dc_resp_id_in    (dc_resp_id),
    .resp_valid_out   (resp_valid),
    .resp_data_out    (resp_data),
    .resp_tag_out     (resp_tag),
    .outstanding_out  (outstanding),
    .idle_out         (idle),
    .err_out          (err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_req(input logic [3:0] tag, input logic [63:0] addr);
    req_valid = 1'b1; req_tag = tag; req_addr = addr;
  endtask

  task automatic send_resp(input logic [3:0] id, input logic [63:0] data);
    dc_resp_valid = 1'b1; dc_resp_id = id; dc_resp_data = data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_tag = '0;
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_data = '0; dc_resp_id = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL reset_dc_valid got %0b want 0", dc_req_valid); end
    checks++; if (dc_req_addr !== 64'h0) begin errors++; $display("FAIL reset_dc_addr got %0h want 0", dc_req_addr); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b want 0", resp_valid); end
    checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %0b want 1", idle); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err got %b want 000", err); end
  endtask

  task automatic test_single();
    dc_req_ready = 1'b1;
    send_req(4'd3, 64'h1000);
    tick();
    req_valid = 1'b0;
    checks++; if (dc_req_valid !== 1'b1) begin errors++; $display("FAIL single_dc_valid got %0b want 1", dc_req_valid); end
    checks++; if (dc_req_addr !== 64'h1000) begin errors++; $display("FAIL single_dc_addr got %0h want 1000", dc_req_addr); end
    checks++; if (dc_req_id !== 4'd3) begin errors++; $display("FAIL single_dc_id got %0d want 3", dc_req_id); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_busy got %0b want 0", idle); end
    tick();
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL single_dc_drained got %0b want 0", dc_req_valid); end
    send_resp(4'd3, 64'hDEAD);
    tick();
    dc_resp_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid got %0b want 1", resp_valid); end
    checks++; if (resp_tag !== 4'd3) begin errors++; $display("FAIL single_resp_tag got %0d want 3", resp_tag); end
    checks++; if (resp_data !== 64'hDEAD) begin errors++; $display("FAIL single_resp_data got %0h want dead", resp_data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got %0b want 1", idle); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %0b want 0", resp_valid); end
  endtask

  task automatic test_backpressure();
    int moved;
    dc_req_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_req(4'(i), 64'h2000 + 64'(i * 8));
      tick();
    end
    req_valid = 1'b0;
    checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL bp_outstanding_full got %0d want 16", outstanding); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL bp_err got %b want 000", err); end
    moved = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (dc_req_valid !== 1'b1 || dc_req_addr !== 64'h2000 || dc_req_id !== 4'd0) moved++;
    end
    checks++; if (moved !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d unstable cycles want 0", moved); end
    dc_req_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dc_req_valid !== 1'b1 || dc_req_id !== 4'(i) || dc_req_addr !== 64'h2000 + 64'(i * 8)) begin
        errors++; $display("FAIL bp_issue_%0d got v=%0b id=%0d addr=%0h want v=1 id=%0d", i, dc_req_valid, dc_req_id, dc_req_addr, i);
      end
      tick();
    end
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %0b want 0", dc_req_valid); end
    for (int i = 0; i < 16; i++) begin
      send_resp(4'(i), 64'h1100 + 64'(i));
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_tag !== 4'(i) || resp_data !== 64'h1100 + 64'(i) || outstanding !== 5'(15 - i)) begin
        errors++; $display("FAIL bp_resp_%0d got v=%0b tag=%0d data=%0h out=%0d want tag=%0d out=%0d", i, resp_valid, resp_tag, resp_data, outstanding, i, 15 - i);
      end
    end
    dc_resp_valid = 1'b0;
    tick();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL bp_idle got %0b want 1", idle); end
  endtask

  task automatic test_out_of_order();
    logic [3:0] order [3];
    order[0] = 4'd7; order[1] = 4'd5; order[2] = 4'd6;
    dc_req_ready = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      send_req(4'(i), 64'h5000 + 64'(i));
      tick();
    end
    req_valid = 1'b0;
    repeat (2) tick();
    checks++; if (dc_req_valid !== 1'b0 || outstanding !== 5'd3) begin errors++; $display("FAIL ooo_issued got v=%0b out=%0d want v=0 out=3", dc_req_valid, outstanding); end
    for (int k = 0; k < 3; k++) begin
      send_resp(order[k], 64'hA0A0_0000 + 64'(order[k]));
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_tag !== order[k] || resp_data !== 64'hA0A0_0000 + 64'(order[k])) begin
        errors++; $display("FAIL ooo_resp_%0d got v=%0b tag=%0d data=%0h want tag=%0d", k, resp_valid, resp_tag, resp_data, order[k]);
      end
    end
    dc_resp_valid = 1'b0;
    tick();
    checks++; if (err !== 3'b000 || idle !== 1'b1) begin errors++; $display("FAIL ooo_clean got err=%b idle=%0b want err=000 idle=1", err, idle); end
  endtask

  task automatic test_flush();
    int leaked;
    dc_req_ready = 1'b1;
    send_req(4'd8, 64'h8000); tick();
    send_req(4'd9, 64'h9000); tick();
    req_valid = 1'b0;
    repeat (2) tick();
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL flush_inflight_issued got %0b want 0", dc_req_valid); end
    dc_req_ready = 1'b0;
    for (int i = 10; i <= 12; i++) begin
      send_req(4'(i), 64'hC000 + 64'(i));
      tick();
    end
    req_valid = 1'b0;
    checks++; if (outstanding !== 5'd5 || dc_req_id !== 4'd10) begin errors++; $display("FAIL flush_pre got out=%0d id=%0d want out=5 id=10", outstanding, dc_req_id); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL flush_outstanding got %0d want 0", outstanding); end
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL flush_queue_emptied got %0b want 0", dc_req_valid); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL flush_pending_idle got %0b want 0", idle); end
    dc_req_ready = 1'b1;
    leaked = 0;
    repeat (3) begin
      tick();
      if (dc_req_valid !== 1'b0) leaked++;
    end
    checks++; if (leaked !== 0) begin errors++; $display("FAIL flush_no_issue got %0d issue cycles want 0", leaked); end
    send_resp(4'd8, 64'h88);
    tick();
    checks++; if (resp_valid !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL flush_late8 got v=%0b idle=%0b want v=0 idle=0", resp_valid, idle); end
    send_resp(4'd9, 64'h99);
    tick();
    dc_resp_valid = 1'b0;
    checks++; if (resp_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL flush_late9 got v=%0b idle=%0b want v=0 idle=1", resp_valid, idle); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL flush_err got %b want 000", err); end
  endtask

  task automatic test_errors();
    dc_req_ready = 1'b1;
    send_req(4'd4, 64'h4000); tick();
    send_req(4'd4, 64'h4400); tick();
    req_valid = 1'b0;
    checks++; if (err !== 3'b010 || outstanding !== 5'd1) begin errors++; $display("FAIL err_dup got err=%b out=%0d want err=010 out=1", err, outstanding); end
    send_resp(4'd9, 64'h9999);
    tick();
    checks++; if (err !== 3'b110 || resp_valid !== 1'b0) begin errors++; $display("FAIL err_spurious got err=%b v=%0b want err=110 v=0", err, resp_valid); end
    send_resp(4'd4, 64'h4444);
    tick();
    dc_resp_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 64'h4444) begin errors++; $display("FAIL err_orig_kept got v=%0b data=%0h want v=1 data=4444", resp_valid, resp_data); end
  endtask

  task automatic test_same_cycle_and_reset();
    do_reset();
    dc_req_ready = 1'b1;
    send_req(4'd2, 64'h3000); tick();
    req_valid = 1'b0;
    tick();
    send_resp(4'd2, 64'hBEEF);
    send_req(4'd2, 64'h3100);
    tick();
    req_valid = 1'b0; dc_resp_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_tag !== 4'd2 || resp_data !== 64'hBEEF) begin errors++; $display("FAIL same_resp got v=%0b tag=%0d data=%0h want v=1 tag=2 data=beef", resp_valid, resp_tag, resp_data); end
    checks++; if (err !== 3'b000 || outstanding !== 5'd1) begin errors++; $display("FAIL same_alloc got err=%b out=%0d want err=000 out=1", err, outstanding); end
    checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 64'h3100) begin errors++; $display("FAIL same_issue got v=%0b addr=%0h want v=1 addr=3100", dc_req_valid, dc_req_addr); end
    tick();
    dc_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_req(4'(i + 8), 64'h6000 + 64'(i));
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dc_req_valid !== 1'b0 || dc_req_addr !== 64'h0 || dc_req_id !== 4'd0) begin errors++; $display("FAIL rst_dc got v=%0b addr=%0h id=%0d want 0", dc_req_valid, dc_req_addr, dc_req_id); end
    checks++; if (resp_valid !== 1'b0 || resp_data !== 64'h0 || resp_tag !== 4'd0) begin errors++; $display("FAIL rst_resp got v=%0b data=%0h tag=%0d want 0", resp_valid, resp_data, resp_tag); end
    checks++; if (outstanding !== 5'd0 || idle !== 1'b1 || err !== 3'b000) begin errors++; $display("FAIL rst_status got out=%0d idle=%0b err=%b want 0/1/000", outstanding, idle, err); end
    tick();
    req_valid = 1'b0;
    rst_n = 1'b1;
    send_resp(4'd9, 64'h1111);
    tick();
    dc_resp_valid = 1'b0;
    checks++; if (resp_valid !== 1'b0 || err !== 3'b100 || outstanding !== 5'd0) begin errors++; $display("FAIL rst_after got v=%0b err=%b out=%0d want v=0 err=100 out=0", resp_valid, err, outstanding); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_out_of_order();
    test_flush();
    test_errors();
    test_same_cycle_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
